// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM encoding, word width, counter sizing.
// IDLE_HELD is only reachable when SPI_MASTER_BURST_EN is defined.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_XFER      = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_IDLE_HELD = 3'd4;

  // Half-period counter width; at least one bit so CLK_DIV=2 still has a counter.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Local-side handshake plus SPI pins of spi_master, bundled with master/slave views.
// hold_ss exists only when SPI_MASTER_BURST_EN is defined.
interface spi_master_if #(parameter int DATA_W = 8);
  logic              start;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              ss;
  logic              sck;
  logic              mosi;
  logic              miso;
`ifdef SPI_MASTER_BURST_EN
  logic              hold_ss;

  modport master (input start, din, miso, hold_ss,
                  output dout, busy, done, ss, sck, mosi);
  modport slave  (output start, din, miso, hold_ss,
                  input dout, busy, done, ss, sck, mosi);
`else
  modport master (input start, din, miso,
                  output dout, busy, done, ss, sck, mosi);
  modport slave  (output start, din, miso,
                  input dout, busy, done, ss, sck, mosi);
`endif
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one tick every CLK_DIV enabled cycles, restarted by i_clr.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int              CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), one MSB-first word per transfer.
// Optional multi-byte frames with ss held low: define SPI_MASTER_BURST_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int            HW        = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_EDGE = HW'(2 * DATA_W - 2);

  logic [2:0]        r_state;
  logic [HW-1:0]     r_hcnt;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic              r_ss;
  logic              r_sck;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;

  logic w_accept;
  logic w_en;
  logic w_tick;

`ifdef SPI_MASTER_BURST_EN
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_IDLE_HELD));
`else
  assign w_accept = bus.start && (r_state == ST_IDLE);
`endif
  assign w_en = (r_state == ST_SETUP) || (r_state == ST_XFER) || (r_state == ST_HOLD);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (w_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_ss    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // MSB goes out immediately; the rest waits for falling edges.
        r_state <= ST_SETUP;
        r_ss    <= 1'b0;
        r_busy  <= 1'b1;
        r_mosi  <= bus.din[DATA_W-1];
        r_tx    <= {bus.din[DATA_W-2:0], 1'b0};
        r_rx    <= '0;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_SETUP: if (w_tick) begin
            r_state <= ST_XFER;
            r_sck   <= 1'b1;
            r_rx    <= {r_rx[DATA_W-2:0], bus.miso};
            r_hcnt  <= '0;
          end
          ST_XFER: if (w_tick) begin
            r_hcnt <= r_hcnt + 1'b1;
            if (r_sck) begin
              r_sck <= 1'b0;
              if (r_hcnt == LAST_EDGE) begin
                r_state <= ST_HOLD;
              end else begin
                r_mosi <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
              end
            end else begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[DATA_W-2:0], bus.miso};
            end
          end
          ST_HOLD: if (w_tick) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_dout <= r_rx;
            r_mosi <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            if (bus.hold_ss) begin
              r_state <= ST_IDLE_HELD;
            end else begin
              r_state <= ST_IDLE;
              r_ss    <= 1'b1;
            end
`else
            r_state <= ST_IDLE;
            r_ss    <= 1'b1;
`endif
          end
`ifdef SPI_MASTER_BURST_EN
          ST_IDLE_HELD: if (!bus.hold_ss) begin
            r_state <= ST_IDLE;
            r_ss    <= 1'b1;
          end
`endif
          default: begin
            r_state <= ST_IDLE;
            r_ss    <= 1'b1;
            r_sck   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout = r_dout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ss   = r_ss;
  assign bus.sck  = r_sck;
  assign bus.mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance 0 at CLK_DIV=4, instance 1 at CLK_DIV=2.
// Burst-frame stimulus is added when SPI_MASTER_BURST_EN is defined.
module tb_spi_master;

  typedef struct {
    logic [7:0] din;
    logic [7:0] rx;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_drv [2];
  logic [7:0] din_drv   [2];
  logic       miso_drv  [2];
  logic       hold_drv  [2];

  logic       w_ss   [2];
  logic       w_sck  [2];
  logic       w_mosi [2];
  logic       w_busy [2];
  logic       w_done [2];
  logic [7:0] w_dout [2];

  logic [7:0] sword [2];
  logic       loopb [2];
  int         divs  [2] = '{4, 2};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_master_if #(.DATA_W(8)) bus ();
    assign bus.start = start_drv[gi];
    assign bus.din   = din_drv[gi];
    assign bus.miso  = miso_drv[gi];
`ifdef SPI_MASTER_BURST_EN
    assign bus.hold_ss = hold_drv[gi];
`endif
    spi_master #(.CLK_DIV((gi == 0) ? 4 : 2), .DATA_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign w_ss[gi]   = bus.ss;
    assign w_sck[gi]  = bus.sck;
    assign w_mosi[gi] = bus.mosi;
    assign w_busy[gi] = bus.busy;
    assign w_done[gi] = bus.done;
    assign w_dout[gi] = bus.dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model, scoreboard and slave pin model.
  exp_t       sb [2][$];
  exp_t       f;
  int         cyc = 0;
  int         free_at [2];
  logic [7:0] mdout   [2];
  int         rises   [2];
  logic [7:0] bits    [2];
  logic       prev_sck[2];
  int         fcnt    [2];
  logic       held    [2];
  logic       s_start [2];
  logic [7:0] s_din   [2];
  logic       s_hold  [2];
  logic       s_rst;
  exp_t       e;

  initial begin
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; mdout[i] = 8'h00; rises[i] = 0; bits[i] = 8'h00;
      prev_sck[i] = 1'b0; fcnt[i] = 0; held[i] = 1'b0; miso_drv[i] = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    s_rst = rst;
    for (int i = 0; i < 2; i++) begin
      s_start[i] = start_drv[i];
      s_din[i]   = din_drv[i];
      s_hold[i]  = hold_drv[i];
    end
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (s_rst) begin
        sb[i].delete();
        free_at[i] = cyc;
        mdout[i]   = 8'h00;
        held[i]    = 1'b0;
        check_eq("rst_ss", w_ss[i], 1);
        check_eq("rst_sck", w_sck[i], 0);
        check_eq("rst_busy", w_busy[i], 0);
        check_eq("rst_done", w_done[i], 0);
        check_eq("rst_dout", w_dout[i], 0);
      end else begin
        if (s_start[i] && (cyc - 1 >= free_at[i])) begin
          e.din = s_din[i];
          e.rx  = loopb[i] ? s_din[i] : sword[i];
          e.acc = cyc - 1;
          sb[i].push_back(e);
          free_at[i] = cyc + 17 * divs[i];
          rises[i] = 0;
          bits[i]  = 8'h00;
          held[i]  = 1'b0;
        end else if (held[i] && !s_hold[i]) begin
          check_eq("held_release_ss", w_ss[i], 1);
          held[i] = 1'b0;
        end
        if (sb[i].size() > 0) begin
          f = sb[i][0];
          if (cyc == f.acc + 1) begin
            check_eq("first_ss", w_ss[i], 0);
            check_eq("first_busy", w_busy[i], 1);
            check_eq("first_mosi", w_mosi[i], f.din[7]);
            check_eq("dout_hold", w_dout[i], mdout[i]);
          end
          if (!prev_sck[i] && w_sck[i]) begin
            rises[i]++;
            bits[i] = {bits[i][6:0], w_mosi[i]};
          end
          if (cyc > f.acc && cyc <= f.acc + 17 * divs[i] && w_ss[i])
            check_eq("ss_low", w_ss[i], 0);
          if (cyc == f.acc + 1 + 17 * divs[i]) begin
            check_eq("done", w_done[i], 1);
            check_eq("dout", w_dout[i], f.rx);
            check_eq("sck_rises", rises[i], 8);
            check_eq("mosi_bits", bits[i], f.din);
            check_eq("done_busy", w_busy[i], 0);
            check_eq("done_ss", w_ss[i], !s_hold[i]);
            $display("xfer dut%0d div=%0d din=0x%02h dout=0x%02h exp=0x%02h done_cycle=%0d",
                     i, divs[i], f.din, w_dout[i], f.rx, cyc);
            mdout[i] = f.rx;
            held[i]  = s_hold[i];
            void'(sb[i].pop_front());
          end else if (w_done[i]) begin
            check_eq("spurious_done", w_done[i], 0);
          end
        end else if (w_done[i]) begin
          check_eq("spurious_done", w_done[i], 0);
        end
      end
      if (w_ss[i] || w_done[i]) fcnt[i] = 0;
      else if (prev_sck[i] && !w_sck[i]) fcnt[i]++;
      miso_drv[i] = loopb[i] ? w_mosi[i] : ((fcnt[i] < 8) ? sword[i][7 - fcnt[i]] : 1'b0);
      prev_sck[i] = w_sck[i];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int i, input logic [7:0] d);
    @(negedge clk);
    din_drv[i]   = d;
    start_drv[i] = 1'b1;
    @(negedge clk);
    start_drv[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_drv[i] = 1'b0; din_drv[i] = 8'h00; hold_drv[i] = 1'b0;
      sword[i] = 8'h00; loopb[i] = 1'b0;
    end
    idle(3);
    rst = 1'b0;
    idle(2);

    // Fixed slave word against a known transmit pattern.
    sword[0] = 8'h3C;
    pulse(0, 8'hA5);
    idle(75);

    // Loopback, back-to-back words: din changes right after the first accept.
    loopb[0] = 1'b1;
    @(negedge clk);
    din_drv[0] = 8'hFF; start_drv[0] = 1'b1;
    @(negedge clk);
    din_drv[0] = 8'h00;
    idle(69);
    start_drv[0] = 1'b0;
    idle(75);
    loopb[0] = 1'b0;

    // Start held continuously: three transfers, 69 cycles apart.
    sword[0] = 8'h5A;
    @(negedge clk);
    din_drv[0] = 8'hC3; start_drv[0] = 1'b1;
    idle(200);
    start_drv[0] = 1'b0;
    idle(20);

    // Start pulses while busy must be ignored.
    sword[0] = 8'h e7;
    pulse(0, 8'h1E);
    idle(9);  pulse(0, 8'hFF);
    idle(19); pulse(0, 8'h00);
    idle(29); pulse(0, 8'h55);
    idle(20);

    // Reset in the middle of a transfer, then a fresh transfer.
    sword[0] = 8'h81;
    pulse(0, 8'h96);
    idle(28);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    sword[0] = 8'h24;
    pulse(0, 8'h5A);
    idle(75);

    // Faster divider on the second instance.
    sword[1] = 8'h66;
    pulse(1, 8'h81);
    idle(40);
    sword[1] = 8'hB1;
    pulse(1, 8'h7E);
    idle(40);

`ifdef SPI_MASTER_BURST_EN
    // Two-word frame with ss held low across the word boundary.
    sword[0] = 8'hC5;
    @(negedge clk);
    hold_drv[0] = 1'b1; din_drv[0] = 8'h12; start_drv[0] = 1'b1;
    @(negedge clk);
    din_drv[0] = 8'h34;
    idle(69);
    start_drv[0] = 1'b0;
    idle(30);
    hold_drv[0] = 1'b0;
    idle(50);
    // Held frame released from IDLE_HELD without a further word.
    @(negedge clk);
    hold_drv[0] = 1'b1; din_drv[0] = 8'h9C; start_drv[0] = 1'b1;
    @(negedge clk);
    start_drv[0] = 1'b0;
    idle(72);
    hold_drv[0] = 1'b0;
    idle(10);
`endif

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master: the initiator end of the link that `spi_slave` answers on the board.
- Drives ss/sck/mosi, samples miso, and exchanges one 8-bit word per transfer, MSB first.
- Sits between local control logic (start/din/dout handshake) and the external SPI pins.
- Used to exercise `spi_slave` in loopback and to talk to off-board SPI peripherals.

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles; legal range ≥2.
- DATA_W, 8, bits per transfer; only 8 is supported in this revision.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a transfer; sampled only in IDLE.
- din  input  8  word to transmit; latched on an accepted start.
- dout  output  8  received word; valid from the done cycle until the next accepted start.
- busy  output  1  high from the cycle after an accepted start through the last HOLD cycle.
- done  output  1  one-cycle pulse at the end of a transfer.
- ss  output  1  slave select, active-low.
- sck  output  1  serial clock; idles low (CPOL=0).
- mosi  output  1  serial data out.
- miso  input  1  serial data in; assumed already synchronous to clk.

Behaviour:
- Reset values, all applied at the rst edge, including mid-transfer: ss=1, sck=0, mosi=0, busy=0, done=0, dout=0x00, state=IDLE, counters=0, shift registers cleared.
- States:
  - IDLE: wait for start.
  - SETUP: ss low, sck low, for CLK_DIV cycles.
  - XFER: 16 sck half-periods of CLK_DIV cycles each.
  - HOLD: sck low, ss low, for CLK_DIV cycles.
  - Transitions: IDLE→SETUP on start; SETUP→XFER; XFER→HOLD after the 8th falling edge; HOLD→IDLE.
- Timing, with the accepting cycle numbered 0:
  - Cycle 1: ss=0, busy=1, mosi=din[7].
  - Rising edge k (k=1..8): cycle 1+(2k-1)·CLK_DIV.
  - Falling edge k: cycle 1+2k·CLK_DIV.
  - Cycle 1+17·CLK_DIV: ss=1, busy=0, done=1, dout updated, state=IDLE.
  - With CLK_DIV=4: rising edges at cycles 5,9+4,… (5,13,…,61), falling edges at 9,17,…,65, done at 69.
- Mode 0 data rules:
  - miso is sampled into the rx shift register on the clk edge that raises sck.
  - mosi advances to the next bit on the edge that lowers sck.
  - No mosi change after the 8th falling edge; mosi returns to 0 when ss rises.
- start while busy is ignored. din is not re-sampled during a transfer.
- start in the done cycle is accepted, because the state is already IDLE. The next transfer begins with ss rising then falling, so ss is high for exactly one cycle between words.
- dout holds its value when a new start is accepted and changes only at the next done.
- start held high continuously produces back-to-back transfers, one every 17·CLK_DIV+1 cycles.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- When defined:
  - Adds input hold_ss (1 bit), sampled in the last HOLD cycle.
  - If hold_ss=1, ss stays low at done and the FSM enters IDLE_HELD (busy=0).
  - A start in IDLE_HELD goes to SETUP with ss kept low, enabling multi-byte frames.
  - IDLE_HELD with hold_ss=0 drives ss=1 the next cycle and goes to IDLE.
- When undefined: no hold_ss port, no IDLE_HELD state, and ss always rises at done.

Decomposition:
- spi_pkg:
  - FSM state encoding (IDLE, SETUP, XFER, HOLD, IDLE_HELD).
  - DATA_W default.
  - Half-period counter width, derived as clog2(CLK_DIV).
- Sub-module spi_clk_div:
  - Half-period tick generator; cleared on start and rst.
  - Emits a tick every CLK_DIV cycles while enabled.
- spi_master keeps the FSM, bit counter (0..15 half-periods), tx/rx shift registers and pin registers.

Test Plan:
- din=0xA5, slave model returns 0x3C, CLK_DIV=4 → mosi bits 1,0,1,0,0,1,0,1 at the 8 rising edges; dout=0x3C and done=1 at cycle 69; exactly 8 sck rises.
- Loopback (miso tied to mosi), din=0xFF then 0x00 → dout=0xFF, then 0x00; ss stays high ≥1 cycle between words.
- start held high for 200 cycles → transfers complete at cycles 69, 138, 207; start pulses issued while busy do not lengthen or restart a transfer.
- rst asserted at cycle 30 mid-transfer → next cycle ss=1, sck=0, busy=0, dout=0x00; a new start behaves as a fresh transfer.
- CLK_DIV=2, din=0x81 → sck period 4 cycles, done at cycle 35, dout matches the slave model.
- SPI_MASTER_BURST_EN, hold_ss=1 for 2 words (0x12, 0x34) → ss low continuously from the first SETUP to the end of the second HOLD; 16 sck rises total; done pulses twice.
